// File: rtl/parking_exit_controller_if.sv
// rtl/parking_exit_controller_if.sv - exit gate sensors, code digits, lamps and occupancy display
interface parking_exit_controller_if;
   logic       sensor_exit;
   logic       sensor_back;
   logic [1:0] exit_code_1;
   logic [1:0] exit_code_2;
   logic       car_entered;
   logic       GREEN_LED;
   logic       RED_LED;
   logic       GATE_OPEN;
   logic [6:0] HEX_1;
   logic [6:0] HEX_2;
   logic       FULL;
   logic       EMPTY;

   modport master (
      output sensor_exit, sensor_back, exit_code_1, exit_code_2, car_entered,
      input  GREEN_LED, RED_LED, GATE_OPEN, HEX_1, HEX_2, FULL, EMPTY
   );

   modport slave (
      input  sensor_exit, sensor_back, exit_code_1, exit_code_2, car_entered,
      output GREEN_LED, RED_LED, GATE_OPEN, HEX_1, HEX_2, FULL, EMPTY
   );
endinterface

// File: rtl/parking_exit_controller.sv
// rtl/parking_exit_controller.sv - exit gate FSM with code check, saturating occupancy and 7-seg display
module parking_exit_controller #(
   parameter int unsigned CAPACITY    = 15,
   parameter int unsigned WAIT_CYCLES = 4,
   parameter logic [1:0]  EXIT_CODE_1 = 2'b10,
   parameter logic [1:0]  EXIT_CODE_2 = 2'b01
) (
   input  logic                    clk,
   input  logic                    reset,
   parking_exit_controller_if.slave bus
);
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WAIT_CODE  = 3'd1;
   localparam logic [2:0] WRONG_CODE = 3'd2;
   localparam logic [2:0] OPEN       = 3'd3;
   localparam logic [2:0] STOP       = 3'd4;

   localparam int unsigned       WAIT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
   localparam logic [6:0]        CAP       = 7'(CAPACITY);

   logic [2:0]        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [6:0]        occ, occ_nxt;
   logic              code_ok;
   logic              commit;
   logic              green_q, red_q, gate_q;
   logic [6:0]        hex1_q, hex2_q;
   logic              full_q, empty_q;

   function automatic logic is_red_state(input logic [2:0] s);
      return (s == WRONG_CODE) || (s == STOP);
   endfunction

   function automatic logic [6:0] seg7(input logic [6:0] d);
      case (d)
         7'd0:    return 7'b1000000;
         7'd1:    return 7'b1111001;
         7'd2:    return 7'b0100100;
         7'd3:    return 7'b0110000;
         7'd4:    return 7'b0011001;
         7'd5:    return 7'b0010010;
         7'd6:    return 7'b0000010;
         7'd7:    return 7'b1111000;
         7'd8:    return 7'b0000000;
         7'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign code_ok = (bus.exit_code_1 == EXIT_CODE_1) && (bus.exit_code_2 == EXIT_CODE_2);
   // The leading car commits its exit when it clears the gate, whether or not a tailgater follows.
   assign commit  = (state == OPEN) && bus.sensor_back;

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         IDLE: begin
            if (bus.sensor_exit && (occ != 7'd0)) begin
               state_nxt = WAIT_CODE;
               wait_nxt  = '0;
            end
         end
         WAIT_CODE: begin
            if (!bus.sensor_exit)
               state_nxt = IDLE;
            else if (wait_cnt == WAIT_LAST)
               state_nxt = code_ok ? OPEN : WRONG_CODE;
            else
               wait_nxt = wait_cnt + 1'b1;
         end
         WRONG_CODE: begin
            if (code_ok)
               state_nxt = OPEN;
            else if (!bus.sensor_exit)
               state_nxt = IDLE;
         end
         OPEN: begin
            if (bus.sensor_back)
               state_nxt = bus.sensor_exit ? STOP : IDLE;
         end
         STOP: begin
            if (code_ok)
               state_nxt = OPEN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An entry and an exit in the same clock cancel out, even at the saturation limits.
   always_comb begin
      occ_nxt = occ;
      if (bus.car_entered && !commit) begin
         if (occ < CAP)
            occ_nxt = occ + 7'd1;
      end else if (commit && !bus.car_entered) begin
         if (occ != 7'd0)
            occ_nxt = occ - 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         occ      <= 7'd0;
         green_q  <= 1'b0;
         red_q    <= 1'b0;
         gate_q   <= 1'b0;
         hex1_q   <= 7'b1000000;
         hex2_q   <= 7'b1000000;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         occ      <= occ_nxt;
         gate_q   <= (state_nxt == OPEN);
         green_q  <= (state_nxt == OPEN) ? ((state == OPEN) ? ~green_q : 1'b1) : 1'b0;
         red_q    <= is_red_state(state_nxt) ? (is_red_state(state) ? ~red_q : 1'b1) : 1'b0;
         // Display and flags follow the registered count, so they trail it by one clock.
         hex1_q   <= seg7(occ / 7'd10);
         hex2_q   <= seg7(occ % 7'd10);
         full_q   <= (occ == CAP);
         empty_q  <= (occ == 7'd0);
      end
   end

   assign bus.GREEN_LED = green_q;
   assign bus.RED_LED   = red_q;
   assign bus.GATE_OPEN = gate_q;
   assign bus.HEX_1     = hex1_q;
   assign bus.HEX_2     = hex2_q;
   assign bus.FULL      = full_q;
   assign bus.EMPTY     = empty_q;
endmodule
